sar_search_ctrl: RTL and testbench
==================================

Name: sar_search_ctrl

Overview:
- Initiator side of the magnitude-compare interface: drives the probe operand into an external combinational magnitude comparator and consumes its L/G/E flags.
- Runs an MSB-first successive-approximation (binary) search to find an unknown W-bit target held on the comparator's other operand.
- Sits above the comparator in any search/threshold-finding datapath; result and done are presented to the requester.

Parameters:
W, 4, operand width in bits (W >= 2)
CW, 3, probe-counter width; must satisfy 2^CW > W

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a search; sampled only in IDLE
cmp_l  input  1  comparator flag: probe < target
cmp_g  input  1  comparator flag: probe > target
cmp_e  input  1  comparator flag: probe == target
probe  output  W  operand driven to the comparator (a-side)
busy  output  1  high while searching
done  output  1  one-cycle pulse when a search ends
result  output  W  found target value; held until next done
err  output  1  flags invalid at end of last search; held until next done
nprobe  output  CW  number of compare cycles used by the last search

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE, probe=0, busy=0, done=0, result=0, err=0, nprobe=0, internal bit index=0, internal counter=0. Reset mid-search aborts the search immediately. No done pulse.
- Comparator path is combinational and external. Flags are valid in the same cycle probe is stable and are sampled at the next rising edge.
- States: IDLE, TEST.
- IDLE: on an edge with start=1, go to TEST. Set probe=1<<(W-1), idx=W-1, busy=1, internal count=0. done returns to 0 on any edge where it is not being asserted.
- TEST, on each edge, increment the count, then evaluate the flags in this priority order:
  - Invalid flags (cmp_l+cmp_g+cmp_e != 1): abort. result=0, err=1, done=1, busy=0, probe=0, nprobe=count, state=IDLE.
  - cmp_e=1: found. result=probe, err=0, done=1, busy=0, probe=0, nprobe=count, state=IDLE.
  - idx==0: last bit. result=probe with bit0 cleared if cmp_g, else probe unchanged. err=0, done=1, busy=0, probe=0, nprobe=count, state=IDLE.
  - Otherwise: if cmp_g, clear probe[idx]; then set probe[idx-1]=1 and idx=idx-1. Stay in TEST.
- Latency: start edge to done edge is 1..W TEST cycles. done is high for exactly one cycle, the cycle after the terminating edge.
- start while busy is ignored and not queued. start held high in IDLE starts back-to-back searches: a new search begins on the first IDLE edge, i.e. the edge on which done is high.
- result, err and nprobe change only on a terminating edge.
- Target 0 is the only value never probed with cmp_e. It ends via the idx==0 path with nprobe=W.

Test Plan:
- W=4, target=5, pulse start -> probes 8,4,6,5. done one cycle after the 4th TEST edge; result=5, nprobe=4, err=0, busy high for 4 cycles.
- target=8 -> single probe 8 gives cmp_e. done after 1 TEST cycle; result=8, nprobe=1.
- target=0 -> probes 8,4,2,1, all cmp_g. result=0, nprobe=4, err=0.
- target=15 -> probes 8,12,14,15. result=15, nprobe=4.
- Force cmp_l=cmp_g=1 on the 2nd probe -> done with err=1, result=0, nprobe=2. A subsequent valid search for target=3 clears err and gives result=3.
- Pulse start again while busy -> ignored, search unaffected.
- Drop rst_n low during the 3rd probe -> probe, busy, done, result and nprobe are 0 immediately and no done pulse follows.
- Hold start high across two searches (targets 9 then 2) -> back-to-back results 9 and 2.

Source files
------------

// File: rtl/sar_search_ctrl.sv
// MSB-first successive-approximation search controller driving an external
// combinational magnitude comparator; reports the found target, an error flag and probe count.
module sar_search_ctrl #(
    parameter int W  = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cmp_l,
    input  logic          cmp_g,
    input  logic          cmp_e,
    output logic [W-1:0]  probe,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          err,
    output logic [CW-1:0] nprobe
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_TEST = 1'b1
    } state_t;

    localparam logic [W-1:0]  ONE_W   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]  MSB_W   = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  ZERO_W  = {W{1'b0}};
    localparam logic [CW-1:0] ZERO_CW = {CW{1'b0}};
    localparam logic [CW-1:0] TOP_IDX = CW'(W - 1);

    // Exactly one of the three comparator flags must be set for a usable answer.
    function automatic logic flags_valid(input logic l, input logic g, input logic e);
        return (l & ~g & ~e) | (~l & g & ~e) | (~l & ~g & e);
    endfunction

    state_t        state_r;
    logic [W-1:0]  probe_r;
    logic [CW-1:0] idx_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r;
    logic          done_r;
    logic [W-1:0]  result_r;
    logic          err_r;
    logic [CW-1:0] nprobe_r;

    logic [W-1:0]  bit_mask_s;
    logic [W-1:0]  settled_s;
    logic [W-1:0]  probe_step_s;
    logic [CW-1:0] cnt_inc_s;
    logic          valid_s;

    // Next-probe arithmetic: settle the bit under test, then try the next lower bit.
    always_comb begin
        bit_mask_s   = ONE_W << idx_r;
        cnt_inc_s    = cnt_r + CW'(1);
        valid_s      = flags_valid(cmp_l, cmp_g, cmp_e);
        if (cmp_g) begin
            settled_s = probe_r & ~bit_mask_s;
        end else begin
            settled_s = probe_r;
        end
        probe_step_s = settled_s | (bit_mask_s >> 1);
    end

    // Search state machine with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            probe_r  <= ZERO_W;
            idx_r    <= ZERO_CW;
            cnt_r    <= ZERO_CW;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= ZERO_W;
            err_r    <= 1'b0;
            nprobe_r <= ZERO_CW;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= ST_TEST;
                        probe_r <= MSB_W;
                        idx_r   <= TOP_IDX;
                        cnt_r   <= ZERO_CW;
                        busy_r  <= 1'b1;
                    end
                end
                ST_TEST: begin
                    cnt_r <= cnt_inc_s;
                    if (!valid_s) begin
                        state_r  <= ST_IDLE;
                        result_r <= ZERO_W;
                        err_r    <= 1'b1;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        probe_r  <= ZERO_W;
                        nprobe_r <= cnt_inc_s;
                    end else if (cmp_e) begin
                        state_r  <= ST_IDLE;
                        result_r <= probe_r;
                        err_r    <= 1'b0;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        probe_r  <= ZERO_W;
                        nprobe_r <= cnt_inc_s;
                    end else if (idx_r == ZERO_CW) begin
                        // At idx 0 the mask is bit 0, so settled_s is the final answer.
                        state_r  <= ST_IDLE;
                        result_r <= settled_s;
                        err_r    <= 1'b0;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        probe_r  <= ZERO_W;
                        nprobe_r <= cnt_inc_s;
                    end else begin
                        done_r  <= 1'b0;
                        probe_r <= probe_step_s;
                        idx_r   <= idx_r - CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    probe_r <= ZERO_W;
                end
            endcase
        end
    end

    assign probe  = probe_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign err    = err_r;
    assign nprobe = nprobe_r;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: table vectors, hand-written corner sequences and
// random searches checked against an arithmetic model of binary search.
module tb_sar_search_ctrl;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          cmp_l;
    logic          cmp_g;
    logic          cmp_e;
    logic [W-1:0]  probe;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          err;
    logic [CW-1:0] nprobe;

    logic [W-1:0]  target_r;
    int            tb_step;
    int            corrupt_step;
    int            n_checks;
    int            n_pass;

    sar_search_ctrl #(.W(W), .CW(CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_l  (cmp_l),
        .cmp_g  (cmp_g),
        .cmp_e  (cmp_e),
        .probe  (probe),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err),
        .nprobe (nprobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External comparator, with an optional forced-invalid answer on one probe step.
    always_comb begin
        if (corrupt_step != 0 && tb_step == corrupt_step) begin
            cmp_l = 1'b1;
            cmp_g = 1'b1;
            cmp_e = 1'b0;
        end else begin
            cmp_l = (probe < target_r);
            cmp_g = (probe > target_r);
            cmp_e = (probe == target_r);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Probes a binary search makes: for target t, the probes on step k equal
    // t's top k-1 bits followed by a 1 in the bit under test.
    function automatic int model_probe(input int t, input int k);
        int sh;
        sh = W - k;
        return ((t >> (sh + 1)) << (sh + 1)) | (1 << sh);
    endfunction

    // Search stops when the probe equals the target: after W - trailing_zeros(t) probes; 0 needs all W.
    function automatic int model_nprobe(input int t);
        int tz;
        if (t == 0) return W;
        tz = 0;
        while (((t >> tz) & 1) == 0) tz++;
        return W - tz;
    endfunction

    // Called on a negedge; start is raised so the next posedge begins a search.
    task automatic run_search(input int tgt, input int corrupt, input bit poke, input bit hold,
                              input int exp_res, input int exp_err, input int exp_n);
        int  steps;
        bit  got_done;
        target_r     = tgt[W-1:0];
        corrupt_step = corrupt;
        tb_step      = 0;
        start        = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        steps    = 0;
        got_done = 1'b0;
        for (int c = 0; c < W + 2 && !got_done; c++) begin
            if (done) begin
                got_done = 1'b1;
                check("result", int'(result), exp_res);
                check("err", int'(err), exp_err);
                check("nprobe", int'(nprobe), exp_n);
                check("busy_cycles", steps, exp_n);
                check("busy_at_done", int'(busy), 0);
                check("probe_at_done", int'(probe), 0);
            end else begin
                steps++;
                tb_step = steps;
                check("busy", int'(busy), 1);
                check("probe", int'(probe), model_probe(tgt, steps));
                if (poke && steps == 2) start = 1'b1;
                else if (!hold) start = 1'b0;
                @(negedge clk);
            end
        end
        if (!got_done) check("done_timeout", 0, 1);
        if (!hold) begin
            @(negedge clk);
            check("done_pulse_width", int'(done), 0);
            check("idle_busy", int'(busy), 0);
        end
    endtask

    typedef struct {
        int tgt;
        int corrupt;
        bit poke;
        int exp_res;
        int exp_err;
        int exp_n;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int t;
        int cor;
        bit pk;
        bit seen_done;
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        target_r     = '0;
        tb_step      = 0;
        corrupt_step = 0;

        vecs[0] = '{5,  0, 1'b0, 5,  0, 4};
        vecs[1] = '{8,  0, 1'b0, 8,  0, 1};
        vecs[2] = '{0,  0, 1'b0, 0,  0, 4};
        vecs[3] = '{15, 0, 1'b0, 15, 0, 4};
        vecs[4] = '{6,  2, 1'b0, 0,  1, 2};
        vecs[5] = '{3,  0, 1'b0, 3,  0, 4};
        vecs[6] = '{13, 0, 1'b1, 13, 0, 4};
        vecs[7] = '{12, 0, 1'b0, 12, 0, 2};

        repeat (2) @(negedge clk);
        check("rst_probe", int'(probe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_nprobe", int'(nprobe), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_search(vecs[i].tgt, vecs[i].corrupt, vecs[i].poke, 1'b0,
                       vecs[i].exp_res, vecs[i].exp_err, vecs[i].exp_n);
        end

        // start held high: second search begins on the edge where done is high
        run_search(9, 0, 1'b0, 1'b1, 9, 0, 4);
        run_search(2, 0, 1'b0, 1'b0, 2, 0, 3);

        // reset during the third probe aborts at once with no done pulse
        target_r     = 4'd5;
        corrupt_step = 0;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_probe", int'(probe), 6);
        #1 rst_n = 1'b0;
        #1;
        check("arst_probe", int'(probe), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_result", int'(result), 0);
        check("arst_nprobe", int'(nprobe), 0);
        check("arst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("no_done_after_rst", int'(seen_done), 0);

        // random searches against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            t   = $urandom_range(0, (1 << W) - 1);
            cor = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W) : 0;
            pk  = (model_nprobe(t) >= 3) && ($urandom_range(0, 1) == 1);
            if (cor != 0 && cor <= model_nprobe(t))
                run_search(t, cor, pk, 1'b0, 0, 1, cor);
            else
                run_search(t, cor, pk, 1'b0, t, 0, model_nprobe(t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
